dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Committed-store buffer between the out-of-order core's data-memory ports and the data memory. Stores retired by the core are queued in a FIFO and drained to memory one per cycle when the memory write port is ready. Loads are checked against all queued stores and the store presented in the same cycle. On a hit the youngest matching data is forwarded; on a miss the load goes to memory. Load data returns one cycle after the request in both cases, matching the memory's one-cycle read latency.

## Interface
Parameters:
- DEPTH, 8, number of store entries; power of two, ≥2
- CW, $clog2(DEPTH+1), width of occupancy count

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dmem_writeEn  in  1  core presents a store this cycle
- dmem_addressStore  in  64  store byte address (8-byte aligned)
- dmem_WriteData  in  64  store data
- dmem_readEn  in  1  core presents a load this cycle
- dmem_addressLoad  in  64  load byte address (8-byte aligned)
- dmem_readData  out  64  load result, valid the cycle after dmem_readEn
- sb_full_o  out  1  count==DEPTH; core must not store
- sb_empty_o  out  1  count==0
- sb_count_o  out  CW  occupied entries
- sb_overflow_o  out  1  sticky: store presented while full
- mem_writeEn_o  out  1  drain write request
- mem_addressStore_o  out  64  head entry address
- mem_WriteData_o  out  64  head entry data
- mem_wready_i  in  1  memory accepts the write this cycle
- mem_readEn_o  out  1  load forwarded to memory (miss only)
- mem_addressLoad_o  out  64  equals dmem_addressLoad
- mem_readData_i  in  64  memory read data, one cycle after mem_readEn_o

## Operation
- The FIFO uses head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a registered count. Each entry holds {addr[63:3], data}.
- Enqueue: dmem_writeEn && !sb_full_o. Writes the tail entry and advances tail.
- A store presented while full is dropped, sets sb_overflow_o, and leaves all state unchanged otherwise. The overflow flag clears only on reset.
- Drain: mem_writeEn_o = !sb_empty_o. The head is driven combinationally. When mem_writeEn_o && mem_wready_i, head advances.
- The count update is +1 on enqueue only, −1 on dequeue only, and unchanged when both happen.
- Full/empty are derived from the registered count. When the buffer is full and draining in the same cycle, an incoming store is still rejected.
- There is no bypass: a store into an empty buffer reaches memory no earlier than the next cycle.
- Load match compares addr[63:3] only. All 64-bit accesses are whole-doubleword; there is no partial-overlap handling.
- Forward priority when dmem_readEn=1:
  1. The incoming store in the same cycle, if dmem_writeEn=1, its address matches, and it is accepted.
  2. Otherwise the youngest valid matching entry, searched from tail−1 back to head. This includes the head entry draining this cycle.
  3. Otherwise a miss.
- Hit: register hit=1 and the forwarded data; mem_readEn_o=0.
- Miss: mem_readEn_o=1; register hit=0.
- Next cycle: dmem_readData = hit_q ? fwd_data_q : mem_readData_i.
- mem_addressLoad_o always equals dmem_addressLoad.

## Timing
- Reset (synchronous), all registered state:
  - head=tail=0, count=0
  - sb_empty_o=1, sb_full_o=0, sb_overflow_o=0
  - hit_q=0, fwd_data_q=0
  - entry contents are don't-care
- Outputs during and after reset:
  - mem_writeEn_o=0
  - mem_readEn_o follows dmem_readEn (a miss)
  - dmem_readData follows mem_readData_i
- Reset asserted mid-drain discards all queued stores. A write accepted in the same edge as reset is not re-issued.
- Latencies:
  - enqueue to earliest memory write: 1 cycle
  - load request to data, hit or miss: 1 cycle
  - status outputs update the cycle after the causing edge
- Throughput: one enqueue, one dequeue and one load per cycle, all concurrently.

## Test plan
- Reset → sb_empty_o=1, sb_count_o=0, mem_writeEn_o=0, sb_overflow_o=0.
- Store A=0x10/D=0x1111 with mem_wready_i=0 for 3 cycles → count=1, mem_writeEn_o=1 with addr 0x10/data 0x1111 held. Raise wready → count=0 next cycle.
- Fill to 8 entries with wready=0 → sb_full_o=1. A 9th store is dropped and sets sb_overflow_o. Then drain 8 with wready=1 → writes appear in order, including across the pointer wrap.
- Stores 0x20←5 then 0x20←9 queued, then load 0x20 → dmem_readData=9 next cycle, mem_readEn_o=0. Load 0x28 → mem_readEn_o=1 and data equals mem_readData_i.
- Same cycle: store 0x30←7 and load 0x30 → result 7. The same with the buffer full → store rejected and the load is a miss.
- Full buffer, a dequeue and a store in the same cycle → store rejected, count=7, sb_overflow_o=1.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Committed-store buffer: FIFO of retired stores drained to data memory one per cycle,
// with youngest-match store-to-load forwarding and a fixed one-cycle load return.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dmem_writeEn,
    input  logic [63:0]   dmem_addressStore,
    input  logic [63:0]   dmem_WriteData,
    input  logic          dmem_readEn,
    input  logic [63:0]   dmem_addressLoad,
    output logic [63:0]   dmem_readData,
    output logic          sb_full_o,
    output logic          sb_empty_o,
    output logic [CW-1:0] sb_count_o,
    output logic          sb_overflow_o,
    output logic          mem_writeEn_o,
    output logic [63:0]   mem_addressStore_o,
    output logic [63:0]   mem_WriteData_o,
    input  logic          mem_wready_i,
    output logic          mem_readEn_o,
    output logic [63:0]   mem_addressLoad_o,
    input  logic [63:0]   mem_readData_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = 61;

    logic [TW-1:0] addr_q [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          hit_q;
    logic [63:0]   fwd_q;

    logic          enq_c;
    logic          deq_c;
    logic          hit_c;
    logic [63:0]   fwd_c;
    logic          unused_ok;

    // Entries keep only the doubleword address; the byte offset is always zero.
    assign unused_ok = &{1'b0, dmem_addressStore[2:0]};

    assign sb_count_o         = count_q;
    assign sb_full_o          = (count_q == CW'(DEPTH));
    assign sb_empty_o         = (count_q == CW'(0));
    assign sb_overflow_o      = overflow_q;
    assign mem_writeEn_o      = !sb_empty_o && !reset;
    assign mem_addressStore_o = {addr_q[head_q], 3'b000};
    assign mem_WriteData_o    = data_q[head_q];
    assign enq_c              = dmem_writeEn && !sb_full_o && !reset;
    assign deq_c              = mem_writeEn_o && mem_wready_i;
    assign mem_addressLoad_o  = dmem_addressLoad;
    assign mem_readEn_o       = dmem_readEn && (reset || !hit_c);
    assign dmem_readData      = (hit_q && !reset) ? fwd_q : mem_readData_i;

    // Oldest-to-youngest scan so the last match wins; the same-cycle store overrides all.
    always_comb begin
        hit_c = 1'b0;
        fwd_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + AW'(i)] == dmem_addressLoad[63:3])) begin
                hit_c = 1'b1;
                fwd_c = data_q[head_q + AW'(i)];
            end
        end
        if (enq_c && (dmem_addressStore[63:3] == dmem_addressLoad[63:3])) begin
            hit_c = 1'b1;
            fwd_c = dmem_WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
            fwd_q      <= '0;
        end else begin
            if (enq_c) tail_q <= tail_q + AW'(1);
            if (deq_c) head_q <= head_q + AW'(1);
            if (enq_c && !deq_c)      count_q <= count_q + CW'(1);
            else if (!enq_c && deq_c) count_q <= count_q - CW'(1);
            if (dmem_writeEn && sb_full_o) overflow_q <= 1'b1;
            hit_q <= dmem_readEn && hit_c;
            fwd_q <= fwd_c;
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (enq_c) begin
            addr_q[tail_q] <= dmem_addressStore[63:3];
            data_q[tail_q] <= dmem_WriteData;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_store_buffer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          dmem_writeEn;
    logic [63:0]   dmem_addressStore;
    logic [63:0]   dmem_WriteData;
    logic          dmem_readEn;
    logic [63:0]   dmem_addressLoad;
    logic [63:0]   dmem_readData;
    logic          sb_full_o;
    logic          sb_empty_o;
    logic [CW-1:0] sb_count_o;
    logic          sb_overflow_o;
    logic          mem_writeEn_o;
    logic [63:0]   mem_addressStore_o;
    logic [63:0]   mem_WriteData_o;
    logic          mem_wready_i;
    logic          mem_readEn_o;
    logic [63:0]   mem_addressLoad_o;
    logic [63:0]   mem_readData_i;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .dmem_writeEn(dmem_writeEn), .dmem_addressStore(dmem_addressStore),
        .dmem_WriteData(dmem_WriteData), .dmem_readEn(dmem_readEn),
        .dmem_addressLoad(dmem_addressLoad), .dmem_readData(dmem_readData),
        .sb_full_o(sb_full_o), .sb_empty_o(sb_empty_o), .sb_count_o(sb_count_o),
        .sb_overflow_o(sb_overflow_o), .mem_writeEn_o(mem_writeEn_o),
        .mem_addressStore_o(mem_addressStore_o), .mem_WriteData_o(mem_WriteData_o),
        .mem_wready_i(mem_wready_i), .mem_readEn_o(mem_readEn_o),
        .mem_addressLoad_o(mem_addressLoad_o), .mem_readData_i(mem_readData_i)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic        ovf_m = 1'b0;
    logic        hit_p = 1'b0;
    logic [63:0] fwd_p = '0;
    logic        chk_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest-match lookup over the model queue, same-cycle accepted store first.
    function automatic void lookup(output logic h, output logic [63:0] d);
        h = 1'b0;
        d = '0;
        if (!dmem_readEn) return;
        if (dmem_writeEn && q.size() < DEPTH && dmem_addressStore[63:3] == dmem_addressLoad[63:3]) begin
            h = 1'b1;
            d = dmem_WriteData;
            return;
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[63:3] == dmem_addressLoad[63:3]) begin
                h = 1'b1;
                d = q[i].d;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        logic        h;
        logic [63:0] d;
        if (chk_on) begin
            lookup(h, d);
            chk("count", 64'(sb_count_o), 64'(q.size()));
            chk("empty", 64'(sb_empty_o), 64'(q.size() == 0));
            chk("full", 64'(sb_full_o), 64'(q.size() == DEPTH));
            chk("overflow", 64'(sb_overflow_o), 64'(ovf_m));
            chk("mem_we", 64'(mem_writeEn_o), 64'(q.size() > 0 && !reset));
            if (q.size() > 0 && !reset) begin
                chk("mem_waddr", mem_addressStore_o, {q[0].a[63:3], 3'b000});
                chk("mem_wdata", mem_WriteData_o, q[0].d);
            end
            chk("mem_re", 64'(mem_readEn_o), 64'(dmem_readEn && (reset || !h)));
            chk("mem_raddr", mem_addressLoad_o, dmem_addressLoad);
            chk("rdata", dmem_readData, (hit_p && !reset) ? fwd_p : mem_readData_i);
        end
    end

    task automatic drive(input logic we, input logic [63:0] wa, input logic [63:0] wd,
                         input logic re, input logic [63:0] ra, input logic wr,
                         input logic [63:0] rd);
        dmem_writeEn      = we;
        dmem_addressStore = wa;
        dmem_WriteData    = wd;
        dmem_readEn       = re;
        dmem_addressLoad  = ra;
        mem_wready_i      = wr;
        mem_readData_i    = rd;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic        h;
        logic [63:0] d;
        logic        full_m;
        @(posedge clk);
        if (reset) begin
            q.delete();
            ovf_m = 1'b0;
            hit_p = 1'b0;
            fwd_p = '0;
        end else begin
            lookup(h, d);
            full_m = (q.size() == DEPTH);
            hit_p  = h;
            fwd_p  = d;
            if (dmem_writeEn && full_m) ovf_m = 1'b1;
            if (q.size() > 0 && mem_wready_i) void'(q.pop_front());
            if (dmem_writeEn && !full_m) q.push_back('{a: dmem_addressStore, d: dmem_WriteData});
        end
        chk_on = 1'b1;
        #1;
    endtask

    task automatic idle(input logic wr);
        drive(1'b0, '0, '0, 1'b0, '0, wr, 64'h5A5A);
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b0);
        #1;
        tick();
        tick();
        reset = 1'b0;
        idle(1'b0);
        #2;
        chk("rst_empty", 64'(sb_empty_o), 64'd1);
        chk("rst_count", 64'(sb_count_o), 64'd0);
        chk("rst_mem_we", 64'(mem_writeEn_o), 64'd0);
        chk("rst_ovf", 64'(sb_overflow_o), 64'd0);

        // Single store held while memory stalls.
        drive(1'b1, 64'h10, 64'h1111, 1'b0, '0, 1'b0, 64'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            #2;
            chk("hold_count", 64'(sb_count_o), 64'd1);
            chk("hold_we", 64'(mem_writeEn_o), 64'd1);
            chk("hold_addr", mem_addressStore_o, 64'h10);
            chk("hold_data", mem_WriteData_o, 64'h1111);
            tick();
        end
        idle(1'b1);
        tick();
        idle(1'b0);
        #2;
        chk("drain_count", 64'(sb_count_o), 64'd0);

        // Fill across the pointer wrap, overflow, then in-order drain.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(64'h100 + i * 8), 64'(64'hA0 + i), 1'b0, '0, 1'b0, 64'h0);
            tick();
        end
        idle(1'b0);
        #2;
        chk("fill_full", 64'(sb_full_o), 64'd1);
        drive(1'b1, 64'h400, 64'hBAD, 1'b0, '0, 1'b0, 64'h0);
        tick();
        idle(1'b0);
        #2;
        chk("ovf_set", 64'(sb_overflow_o), 64'd1);
        chk("ovf_count", 64'(sb_count_o), 64'd8);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            #2;
            chk("order_addr", mem_addressStore_o, 64'(64'h100 + i * 8));
            chk("order_data", mem_WriteData_o, 64'(64'hA0 + i));
            tick();
        end
        idle(1'b0);
        #2;
        chk("after_drain_empty", 64'(sb_empty_o), 64'd1);

        // Youngest of two matching stores is forwarded; a different doubleword misses.
        drive(1'b1, 64'h20, 64'd5, 1'b0, '0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 64'h20, 64'd9, 1'b0, '0, 1'b0, 64'h0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 64'h20, 1'b0, 64'hDEAD);
        #2;
        chk("fwd_mem_re", 64'(mem_readEn_o), 64'd0);
        tick();
        drive(1'b0, '0, '0, 1'b1, 64'h28, 1'b0, 64'hDEAD);
        #2;
        chk("fwd_data", dmem_readData, 64'd9);
        chk("miss_mem_re", 64'(mem_readEn_o), 64'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 64'hBEEF);
        #2;
        chk("miss_data", dmem_readData, 64'hBEEF);

        // Same-cycle store forwards to the load.
        drive(1'b1, 64'h30, 64'd7, 1'b1, 64'h30, 1'b0, 64'h0);
        #2;
        chk("same_mem_re", 64'(mem_readEn_o), 64'd0);
        tick();
        idle(1'b0);
        #2;
        chk("same_data", dmem_readData, 64'd7);

        // Full buffer: same-cycle store rejected, load misses.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(64'h200 + i * 8), 64'(64'hC0 + i), 1'b0, '0, 1'b0, 64'h0);
            tick();
        end
        drive(1'b1, 64'h38, 64'h77, 1'b1, 64'h38, 1'b0, 64'h1234);
        #2;
        chk("full_mem_re", 64'(mem_readEn_o), 64'd1);
        tick();
        idle(1'b0);
        mem_readData_i = 64'h4321;
        #2;
        chk("full_rdata", dmem_readData, 64'h4321);
        chk("full_count", 64'(sb_count_o), 64'd8);

        // Full with concurrent dequeue and store: store still rejected.
        drive(1'b1, 64'h500, 64'h55, 1'b0, '0, 1'b1, 64'h0);
        tick();
        idle(1'b0);
        #2;
        chk("deq_store_count", 64'(sb_count_o), 64'd7);
        chk("deq_store_ovf", 64'(sb_overflow_o), 64'd1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("rst2_ovf", 64'(sb_overflow_o), 64'd0);
        chk("rst2_count", 64'(sb_count_o), 64'd0);

        // Randomized traffic over a small address pool to force frequent matches.
        for (int n = 0; n < 2000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 60,
                  64'($urandom_range(0, 7) * 8),
                  {$urandom, $urandom},
                  $urandom_range(0, 1) == 1,
                  64'($urandom_range(0, 8) * 8),
                  $urandom_range(0, 99) < 45,
                  {$urandom, $urandom});
            tick();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
